aes_inv_key_scheduler: RTL and testbench
========================================

AES_INV_KEY_SCHEDULER -- requirements
Module: aes_inv_key_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; both port names are given in REQ-002 and REQ-003.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 key_load  input  1  one-cycle pulse; captures cipher_key and starts expansion.
REQ-005 cipher_key  input  128  AES-128 key; bits [127:96] are word w0 and bits [31:0] are w3.
REQ-006 begin_round  input  1  from the decipher core; rewinds the inverse pointer to round 9.
REQ-007 rkey_en  input  1  from the decipher core; steps round_key_inv back one round.
REQ-008 round_key_10  output  128  final round key K10, registered.
REQ-009 round_key_inv  output  128  current inverse round key K_idx, registered.
REQ-010 key_ready  output  1  high when round_key_10 and round_key_inv are valid.
REQ-011 inv_round  output  4  current idx (9..0) of round_key_inv.

Function
REQ-012 The FSM SHALL have three states: IDLE, EXPAND and READY.
REQ-013 IDLE SHALL hold all outputs at zero; key_load moves the FSM to EXPAND and loads the working key with cipher_key and the counter with 1.
REQ-014 Each EXPAND cycle SHALL compute one forward round: w0'=w0^SubWord(RotWord(w3))^Rcon[cnt], then w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-015 After the cycle with cnt=10, the FSM SHALL register K10 into round_key_10 and enter READY; this is 10 cycles after key_load.
REQ-016 On entry to READY, round_key_inv SHALL equal K9, inv_round SHALL be 9 and key_ready SHALL be 1.
REQ-017 The one-cycle inverse step from K_r to K_(r-1) SHALL compute w3=w3^w2, w2=w2^w1, w1=w1^w0, then w0=w0^SubWord(RotWord(new w3))^Rcon[r].
REQ-018 Entry into READY SHALL compute K9 from K10 in the same cycle that K10 is registered; key_ready never shows a stale key.
REQ-019 In READY, an rkey_en with inv_round>0 SHALL load K_(inv_round-1) and decrement inv_round on the next edge.
REQ-020 In READY, an rkey_en with inv_round=0 SHALL hold K0 and idx 0 (saturate; no wrap).
REQ-021 begin_round in READY SHALL reload K9 and set inv_round to 9; if begin_round and rkey_en are both high, begin_round wins.
REQ-022 key_load in EXPAND or READY SHALL restart expansion: key_ready drops next cycle and outputs are cleared until the new READY.
REQ-023 rkey_en and begin_round SHALL be ignored outside READY.
REQ-024 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 (8-bit values, placed in the MSB byte of the word).

Reset
REQ-025 While rst is high, the FSM SHALL be in IDLE and all registers and outputs SHALL be 0; this applies at any time, including mid-EXPAND, and no partial key remains afterwards.
REQ-026 After rst is released, the block SHALL need a fresh key_load before key_ready can assert.

Structure
REQ-027 A shared package aes_pkg SHALL hold the Rcon table, the FSM state encoding and the constant NUM_ROUNDS=10.
REQ-028 The four-byte S-box plus RotWord SHALL be one sub-module, aes_key_subword; it is instantiated once for the forward step and once for the inverse step.
REQ-029 The forward (REQ-014) and inverse (REQ-017) expansion steps SHALL be combinational functions feeding the registers.

Verification
REQ-030 Scenario: key 2b7e151628aed2a6abf7158809cf4f3c -> after 10 cycles, round_key_10=d014f9a8c9ee2589e13f0cc8b6630ca6 and round_key_inv=ac7766f319fadc2128d12941575c006e.
REQ-031 Scenario: same key, 9 rkey_en pulses -> round_key_inv=2b7e151628aed2a6abf7158809cf4f3c with inv_round=0; a 10th pulse leaves it unchanged.
REQ-032 Scenario: key 000102030405060708090a0b0c0d0e0f -> round_key_10=13111d7fe3944a17f307a78b4d2b30c5.
REQ-033 Scenario: after 5 rkey_en pulses, assert begin_round and rkey_en together -> inv_round=9 and round_key_inv=K9.
REQ-034 Scenario: assert rst at EXPAND cycle 4 -> all outputs 0 and FSM in IDLE; a new key_load gives correct K10 10 cycles later.
REQ-035 Scenario: key_load in READY with a new key -> key_ready low next cycle, then high after 10 cycles with the new K10.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: FSM encoding, round
// count, Rcon table and the forward/inverse round-step functions.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // K_(r-1) -> K_r; sub is SubWord(RotWord(w3 of K_(r-1)))
  function automatic logic [127:0] fwd_step(
    input logic [127:0] k,
    input logic [31:0]  sub,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // K_r -> K_(r-1); sub is SubWord(RotWord(recovered w3))
  function automatic logic [127:0] inv_step(
    input logic [127:0] k,
    input logic [31:0]  sub,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_key_subword.sv
// SubWord(RotWord(w)) for the AES key schedule: rotate left
// one byte, then pass each byte through the AES S-box.
module aes_key_subword (
  input  logic [31:0] word_i,
  output logic [31:0] sub_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // entry x sits at bits [8*(255-x)+7 -: 8]
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  logic [31:0] rot;

  assign rot   = {word_i[23:0], word_i[31:24]};
  assign sub_o = {sbox(rot[31:24]), sbox(rot[23:16]),
                  sbox(rot[15:8]),  sbox(rot[7:0])};

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// AES-128 key expansion to K10, then on-the-fly inverse
// round keys K9..K0 stepped by the decipher core.
module aes_inv_key_scheduler
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  input  logic         begin_round,
  input  logic         rkey_en,
  output logic [127:0] round_key_10,
  output logic [127:0] round_key_inv,
  output logic         key_ready,
  output logic [3:0]   inv_round
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  localparam logic [3:0] IDX9 = 4'(NUM_ROUNDS - 1);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rk10_q, rk10_d;
  logic [127:0] rkinv_q, rkinv_d;
  logic         ready_q, ready_d;
  logic [3:0]   idx_q, idx_d;

  logic [31:0]  fwd_sub, inv_sub, inv_w3;
  logic [127:0] fwd_key, inv_src, inv_key;
  logic [7:0]   inv_rc;

  aes_key_subword u_fwd_sub (
    .word_i (key_q[31:0]),
    .sub_o  (fwd_sub)
  );

  assign fwd_key = fwd_step(key_q, fwd_sub, rcon(cnt_q));

  // K10 is the source on READY entry and on rewind
  always_comb begin
    inv_src = rkinv_q;
    inv_rc  = rcon(idx_q);
    if (state_q == ST_EXPAND) begin
      inv_src = fwd_key;
      inv_rc  = rcon(LAST);
    end else if (begin_round) begin
      inv_src = rk10_q;
      inv_rc  = rcon(LAST);
    end
  end

  assign inv_w3 = inv_src[31:0] ^ inv_src[63:32];

  aes_key_subword u_inv_sub (
    .word_i (inv_w3),
    .sub_o  (inv_sub)
  );

  assign inv_key = inv_step(inv_src, inv_sub, inv_rc);

  // next-state and output-register logic
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    rk10_d  = rk10_q;
    rkinv_d = rkinv_q;
    ready_d = ready_q;
    idx_d   = idx_q;
    if (key_load) begin
      state_d = ST_EXPAND;
      key_d   = cipher_key;
      cnt_d   = 4'd1;
      rk10_d  = '0;
      rkinv_d = '0;
      ready_d = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_EXPAND: begin
          key_d = fwd_key;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            state_d = ST_READY;
            key_d   = '0;
            cnt_d   = '0;
            rk10_d  = fwd_key;
            rkinv_d = inv_key;
            ready_d = 1'b1;
            idx_d   = IDX9;
          end
        end
        ST_READY: begin
          if (begin_round) begin
            rkinv_d = inv_key;
            idx_d   = IDX9;
          end else if (rkey_en && idx_q != 4'd0) begin
            rkinv_d = inv_key;
            idx_d   = idx_q - 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state and output registers, cleared by async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      rk10_q  <= '0;
      rkinv_q <= '0;
      ready_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      rk10_q  <= rk10_d;
      rkinv_q <= rkinv_d;
      ready_q <= ready_d;
      idx_q   <= idx_d;
    end
  end

  assign round_key_10  = rk10_q;
  assign round_key_inv = rkinv_q;
  assign key_ready     = ready_q;
  assign inv_round     = idx_q;

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// Bench for aes_inv_key_scheduler: word-level AES-128 key
// schedule model built from GF(2^8) math, plus literal vectors.
module tb_aes_inv_key_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         begin_round;
  logic         rkey_en;
  logic [127:0] round_key_10;
  logic [127:0] round_key_inv;
  logic         key_ready;
  logic [3:0]   inv_round;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] KEY2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clk = ~clk;

  aes_inv_key_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .key_load      (key_load),
    .cipher_key    (cipher_key),
    .begin_round   (begin_round),
    .rkey_en       (rkey_en),
    .round_key_10  (round_key_10),
    .round_key_inv (round_key_inv),
    .key_ready     (key_ready),
    .inv_round     (inv_round)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0]   sb [256];
  logic [127:0] rk [11];
  int m_phase = 0;
  int m_left  = 0;
  int m_idx   = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
            ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // behaviour of the block, one update per clock edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_idx = 0;
    end else if (key_load) begin
      m_phase = 1; m_left = 10; m_idx = 0;
      expand(cipher_key);
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin m_phase = 2; m_idx = 9; end
    end else if (m_phase == 2) begin
      if (begin_round) m_idx = 9;
      else if (rkey_en && m_idx > 0) m_idx--;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    logic rdy;
    rdy = (m_phase == 2);
    chk("key_ready", key_ready, rdy);
    chk("round_key_10", round_key_10, rdy ? rk[10] : '0);
    chk("round_key_inv", round_key_inv, rdy ? rk[m_idx] : '0);
    chk("inv_round", inv_round, rdy ? 4'(m_idx) : 4'd0);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input logic [127:0] k);
    cipher_key = k; key_load = 1'b1;
    step(1);
    key_load = 1'b0;
  endtask

  task automatic pulse(input logic re, input logic br);
    rkey_en = re; begin_round = br;
    step(1);
    rkey_en = 1'b0; begin_round = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, key_ready, 1'b0);
    chk({tag, "_k10"}, round_key_10, '0);
    chk({tag, "_kinv"}, round_key_inv, '0);
    chk({tag, "_idx"}, inv_round, 4'd0);
  endtask

  initial begin
    rst = 1'b1; key_load = 0; begin_round = 0; rkey_en = 0;
    cipher_key = '0;
    build_sbox();
    chk("model_sbox_00", sb[0], 8'h63);
    chk("model_sbox_53", sb[8'h53], 8'hed);
    expand(KEY1);
    chk("model_k1_10", rk[10], K1_10);
    chk("model_k1_9", rk[9], K1_9);
    expand(KEY2);
    chk("model_k2_10", rk[10], K2_10);

    step(3);
    chk_zero("reset");
    rst = 1'b0;
    pulse(1'b1, 1'b1);
    step(2);
    chk_zero("no_load");

    load(KEY1);
    step(9);
    chk("lat_not_ready", key_ready, 1'b0);
    step(1);
    chk("lat_ready", key_ready, 1'b1);
    chk("k1_k10", round_key_10, K1_10);
    chk("k1_k9", round_key_inv, K1_9);
    chk("k1_idx9", inv_round, 4'd9);

    repeat (9) pulse(1'b1, 1'b0);
    chk("k1_k0", round_key_inv, KEY1);
    chk("k1_idx0", inv_round, 4'd0);
    pulse(1'b1, 1'b0);
    chk("sat_k0", round_key_inv, KEY1);
    chk("sat_idx0", inv_round, 4'd0);

    pulse(1'b0, 1'b1);
    chk("rewind_idx", inv_round, 4'd9);
    repeat (5) pulse(1'b1, 1'b0);
    chk("five_idx", inv_round, 4'd4);
    pulse(1'b1, 1'b1);
    chk("both_idx", inv_round, 4'd9);
    chk("both_k9", round_key_inv, K1_9);
    step(2);

    load(KEY2);
    chk("reload_drop", key_ready, 1'b0);
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    step(7);
    chk("k2_not_ready", key_ready, 1'b0);
    step(1);
    chk("k2_ready", key_ready, 1'b1);
    chk("k2_k10", round_key_10, K2_10);
    repeat (9) pulse(1'b1, 1'b0);
    chk("k2_k0", round_key_inv, KEY2);

    load(KEY1);
    step(4);
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    step(1);
    rst = 1'b0;
    step(12);
    chk_zero("rst_after");
    load(KEY1);
    step(10);
    chk("post_rst_ready", key_ready, 1'b1);
    chk("post_rst_k10", round_key_10, K1_10);

    load(KEY2);
    step(3);
    load(KEY1);
    step(10);
    chk("restart_ready", key_ready, 1'b1);
    chk("restart_k10", round_key_10, K1_10);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
